isa_writeback: RTL and testbench

Writeback stage of the pipelined ISA core, directly downstream of the execute stage. It consumes the execute result (destination address, 9-bit result, load flag) and commits it into an 8×8 architectural register file. It serves three combinational read ports with same-cycle write bypass for the decode stage. It also arbitrates a host/debug write port and keeps a sticky add-overflow flag plus retire and load counters.

---
 rtl/isa_pkg.sv | 21 ++
 rtl/isa_regfile.sv | 37 +++
 rtl/isa_writeback.sv | 112 +++++++++++
 tb/tb_isa_writeback.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/isa_pkg.sv
// Shared definitions for the ISA core pipeline.
//   DATA_W / ADDR_W / NREGS / CNT_W : datapath and counter sizing
//   OP_LOAD / OP_ADD                : opcode constants used by decode/execute
//   wr_req_t                        : one register-file write (enable, address, data)
package isa_pkg;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 3;
    localparam int NREGS  = 1 << ADDR_W;
    localparam int CNT_W  = 16;

    localparam logic [6:0] OP_LOAD = 7'd1;
    localparam logic [6:0] OP_ADD  = 7'd2;

    typedef struct packed {
        logic              en;
        logic [ADDR_W-1:0] adr;
        logic [DATA_W-1:0] data;
    } wr_req_t;

endpackage

// File: rtl/isa_regfile.sv
// Architectural register file: NREGS x DATA_W, reset to reg[i] = i.
//   clk, rst_n            : clock, async active-low reset
//   wr_i                  : single write port, committed on the rising edge
//   rd_adr_{a,b,c}_i      : read addresses
//   rd_data_{a,b,c}_o     : combinational read data, bypassed from wr_i
module isa_regfile
    import isa_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  wr_req_t           wr_i,
    input  logic [ADDR_W-1:0] rd_adr_a_i,
    input  logic [ADDR_W-1:0] rd_adr_b_i,
    input  logic [ADDR_W-1:0] rd_adr_c_i,
    output logic [DATA_W-1:0] rd_data_a_o,
    output logic [DATA_W-1:0] rd_data_b_o,
    output logic [DATA_W-1:0] rd_data_c_o
);

    logic [DATA_W-1:0] mem_q [NREGS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                mem_q[i] <= DATA_W'(i);
            end
        end else if (wr_i.en) begin
            mem_q[wr_i.adr] <= wr_i.data;
        end
    end

    // Same-cycle bypass so decode sees a write in the cycle it is presented.
    assign rd_data_a_o = (wr_i.en && (wr_i.adr == rd_adr_a_i)) ? wr_i.data : mem_q[rd_adr_a_i];
    assign rd_data_b_o = (wr_i.en && (wr_i.adr == rd_adr_b_i)) ? wr_i.data : mem_q[rd_adr_b_i];
    assign rd_data_c_o = (wr_i.en && (wr_i.adr == rd_adr_c_i)) ? wr_i.data : mem_q[rd_adr_c_i];

endmodule

// File: rtl/isa_writeback.sv
// Writeback stage: commits execute results (or host writes when execute is
// idle) into the register file, tracks sticky add overflow and retire/load
// counts, and registers a copy of the last commit.
//   ex_*            : execute result; ex_data[DATA_W] is the add carry
//   host_wr_*       : host/debug write port, accepted when execute is idle
//   rd_adr/rd_data  : three combinational bypassed read ports for decode
//   ovf_clr/ovf_flag: sticky overflow (set beats clear)
//   retire_cnt/load_cnt : wrapping commit counters
//   wb_*_q          : registered last commit
module isa_writeback
    import isa_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ex_valid,
    input  logic [ADDR_W-1:0] ex_adr,
    input  logic [DATA_W:0]   ex_data,
    input  logic              ex_load,
    input  logic              host_wr_valid,
    input  logic [ADDR_W-1:0] host_wr_adr,
    input  logic [DATA_W-1:0] host_wr_data,
    output logic              host_wr_ready,
    input  logic [ADDR_W-1:0] rd_adr_a,
    input  logic [ADDR_W-1:0] rd_adr_b,
    input  logic [ADDR_W-1:0] rd_adr_c,
    output logic [DATA_W-1:0] rd_data_a,
    output logic [DATA_W-1:0] rd_data_b,
    output logic [DATA_W-1:0] rd_data_c,
    input  logic              ovf_clr,
    output logic              ovf_flag,
    output logic [CNT_W-1:0]  retire_cnt,
    output logic [CNT_W-1:0]  load_cnt,
    output logic              wb_valid_q,
    output logic [ADDR_W-1:0] wb_adr_q,
    output logic [DATA_W-1:0] wb_data_q
);

    wr_req_t            wr_sel;
    logic               ovf_q, ovf_d;
    logic [CNT_W-1:0]   retire_q, retire_d;
    logic [CNT_W-1:0]   load_q, load_d;

    // Execute always wins; nothing commits (and nothing is bypassed) in reset.
    always_comb begin
        wr_sel = '0;
        if (rst_n) begin
            if (ex_valid) begin
                wr_sel.en   = 1'b1;
                wr_sel.adr  = ex_adr;
                wr_sel.data = ex_data[DATA_W-1:0];
            end else if (host_wr_valid) begin
                wr_sel.en   = 1'b1;
                wr_sel.adr  = host_wr_adr;
                wr_sel.data = host_wr_data;
            end
        end
    end

    assign host_wr_ready = rst_n & ~ex_valid;

    always_comb begin
        ovf_d    = ovf_q;
        retire_d = retire_q;
        load_d   = load_q;
        if (ovf_clr) begin
            ovf_d = 1'b0;
        end
        if (ex_valid) begin
            retire_d = retire_q + CNT_W'(1);
            if (ex_load) begin
                load_d = load_q + CNT_W'(1);
            end else if (ex_data[DATA_W]) begin
                ovf_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q      <= 1'b0;
            retire_q   <= '0;
            load_q     <= '0;
            wb_valid_q <= 1'b0;
            wb_adr_q   <= '0;
            wb_data_q  <= '0;
        end else begin
            ovf_q      <= ovf_d;
            retire_q   <= retire_d;
            load_q     <= load_d;
            wb_valid_q <= wr_sel.en;
            wb_adr_q   <= wr_sel.adr;
            wb_data_q  <= wr_sel.data;
        end
    end

    assign ovf_flag   = ovf_q;
    assign retire_cnt = retire_q;
    assign load_cnt   = load_q;

    isa_regfile u_regfile (
        .clk         (clk),
        .rst_n       (rst_n),
        .wr_i        (wr_sel),
        .rd_adr_a_i  (rd_adr_a),
        .rd_adr_b_i  (rd_adr_b),
        .rd_adr_c_i  (rd_adr_c),
        .rd_data_a_o (rd_data_a),
        .rd_data_b_o (rd_data_b),
        .rd_data_c_o (rd_data_c)
    );

endmodule

// File: tb/tb_isa_writeback.sv
module tb_isa_writeback;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ex_valid;
    logic [2:0]  ex_adr;
    logic [8:0]  ex_data;
    logic        ex_load;
    logic        host_wr_valid;
    logic [2:0]  host_wr_adr;
    logic [7:0]  host_wr_data;
    logic        host_wr_ready;
    logic [2:0]  rd_adr_a, rd_adr_b, rd_adr_c;
    logic [7:0]  rd_data_a, rd_data_b, rd_data_c;
    logic        ovf_clr;
    logic        ovf_flag;
    logic [15:0] retire_cnt, load_cnt;
    logic        wb_valid_q;
    logic [2:0]  wb_adr_q;
    logic [7:0]  wb_data_q;

    isa_writeback dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .ex_valid      (ex_valid),
        .ex_adr        (ex_adr),
        .ex_data       (ex_data),
        .ex_load       (ex_load),
        .host_wr_valid (host_wr_valid),
        .host_wr_adr   (host_wr_adr),
        .host_wr_data  (host_wr_data),
        .host_wr_ready (host_wr_ready),
        .rd_adr_a      (rd_adr_a),
        .rd_adr_b      (rd_adr_b),
        .rd_adr_c      (rd_adr_c),
        .rd_data_a     (rd_data_a),
        .rd_data_b     (rd_data_b),
        .rd_data_c     (rd_data_c),
        .ovf_clr       (ovf_clr),
        .ovf_flag      (ovf_flag),
        .retire_cnt    (retire_cnt),
        .load_cnt      (load_cnt),
        .wb_valid_q    (wb_valid_q),
        .wb_adr_q      (wb_adr_q),
        .wb_data_q     (wb_data_q)
    );

    always #5 clk = ~clk;

    localparam int K_RDA = 0, K_RDB = 1, K_RDC = 2, K_OVF = 3, K_RET = 4,
                   K_LOAD = 5, K_RDY = 6, K_WBV = 7, K_WBA = 8, K_WBD = 9;

    typedef struct {
        int          cyc;
        int          kind;
        logic [15:0] val;
        string       name;
    } sb_t;

    sb_t  sb_q[$];
    int   cyc = 0;
    int   n_vec = 0;
    int   n_err = 0;
    logic [15:0] act;

    always @(posedge clk) cyc++;

    function automatic logic [15:0] sample(input int kind);
        case (kind)
            K_RDA:   return {8'h0, rd_data_a};
            K_RDB:   return {8'h0, rd_data_b};
            K_RDC:   return {8'h0, rd_data_c};
            K_OVF:   return {15'h0, ovf_flag};
            K_RET:   return retire_cnt;
            K_LOAD:  return load_cnt;
            K_RDY:   return {15'h0, host_wr_ready};
            K_WBV:   return {15'h0, wb_valid_q};
            K_WBA:   return {13'h0, wb_adr_q};
            default: return {8'h0, wb_data_q};
        endcase
    endfunction

    // Expected value for the cycle 'dly' cycles from now (checked at negedge).
    task automatic expect_v(input int kind, input logic [15:0] val, input int dly, input string name);
        sb_t e;
        e.cyc  = cyc + dly;
        e.kind = kind;
        e.val  = val;
        e.name = name;
        sb_q.push_back(e);
    endtask

    // Monitor: compare every entry due this cycle against the DUT outputs.
    always @(negedge clk) begin
        for (int i = sb_q.size() - 1; i >= 0; i--) begin
            if (sb_q[i].cyc == cyc) begin
                act = sample(sb_q[i].kind);
                n_vec++;
                if (act !== sb_q[i].val) begin
                    n_err++;
                    $display("FAIL %s (cycle %0d): got %h expected %h", sb_q[i].name, cyc, act, sb_q[i].val);
                end
                sb_q.delete(i);
            end else if (sb_q[i].cyc < cyc) begin
                n_vec++;
                n_err++;
                $display("FAIL %s: never sampled (due cycle %0d)", sb_q[i].name, sb_q[i].cyc);
                sb_q.delete(i);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        ex_valid = 1'b0; ex_adr = '0; ex_data = '0; ex_load = 1'b0;
        host_wr_valid = 1'b0; host_wr_adr = '0; host_wr_data = '0;
        rd_adr_a = 3'd5; rd_adr_b = 3'd0; rd_adr_c = 3'd7;
        ovf_clr = 1'b0;

        step();
        expect_v(K_RDY, 16'd0, 0, "rdy_in_reset");
        expect_v(K_WBV, 16'd0, 0, "wbv_in_reset");

        // Reset released: init pattern, counters zero, host ready.
        step();
        rst_n = 1'b1;
        expect_v(K_RDA, 16'h05, 0, "init_rd_a");
        expect_v(K_RDB, 16'h00, 0, "init_rd_b");
        expect_v(K_RDC, 16'h07, 0, "init_rd_c");
        expect_v(K_RET, 16'd0, 0, "init_retire");
        expect_v(K_LOAD, 16'd0, 0, "init_load");
        expect_v(K_OVF, 16'd0, 0, "init_ovf");
        expect_v(K_RDY, 16'd1, 0, "init_ready");

        // Overflowing add to r3: bypass low byte, ovf set next cycle.
        step();
        ex_valid = 1'b1; ex_adr = 3'd3; ex_data = 9'h10A; ex_load = 1'b0;
        rd_adr_a = 3'd3;
        expect_v(K_RDA, 16'h0A, 0, "add_bypass");
        expect_v(K_RDY, 16'd0, 0, "ready_low_ex");
        expect_v(K_OVF, 16'd1, 1, "add_ovf_set");
        expect_v(K_RET, 16'd1, 1, "retire_1");
        expect_v(K_LOAD, 16'd0, 1, "load_0");
        expect_v(K_WBV, 16'd1, 1, "wbv_add");
        expect_v(K_WBA, 16'd3, 1, "wba_add");
        expect_v(K_WBD, 16'h0A, 1, "wbd_add");

        // Load with carry bit to r2.
        step();
        ex_adr = 3'd2; ex_data = 9'h1FF; ex_load = 1'b1;
        rd_adr_b = 3'd2;
        expect_v(K_RDB, 16'hFF, 0, "load_bypass");
        expect_v(K_RDA, 16'h0A, 0, "r3_array");
        expect_v(K_LOAD, 16'd1, 1, "load_1");
        expect_v(K_RET, 16'd2, 1, "retire_2");
        expect_v(K_OVF, 16'd1, 1, "ovf_hold");

        // Clear overflow.
        step();
        ex_valid = 1'b0; ovf_clr = 1'b1;
        expect_v(K_RDB, 16'hFF, 0, "r2_array");
        expect_v(K_OVF, 16'd0, 1, "ovf_cleared");

        // Load with carry must not set overflow.
        step();
        ovf_clr = 1'b0;
        ex_valid = 1'b1; ex_adr = 3'd1; ex_data = 9'h100; ex_load = 1'b1;
        rd_adr_c = 3'd1;
        expect_v(K_RDC, 16'h00, 0, "load_trunc");
        expect_v(K_OVF, 16'd0, 1, "load_no_ovf");
        expect_v(K_LOAD, 16'd2, 1, "load_2");
        expect_v(K_RET, 16'd3, 1, "retire_3");

        // Overflow set together with clear: set wins.
        step();
        ex_adr = 3'd6; ex_data = 9'h180; ex_load = 1'b0; ovf_clr = 1'b1;
        rd_adr_c = 3'd6;
        expect_v(K_RDC, 16'h80, 0, "add6_bypass");
        expect_v(K_OVF, 16'd1, 1, "set_beats_clr");
        expect_v(K_RET, 16'd4, 1, "retire_4");

        // Host write to r4 blocked by 3 ex commits to r4.
        step();
        ovf_clr = 1'b0;
        ex_adr = 3'd4; ex_data = 9'h022; ex_load = 1'b0;
        host_wr_valid = 1'b1; host_wr_adr = 3'd4; host_wr_data = 8'h55;
        rd_adr_a = 3'd4; rd_adr_b = 3'd4;
        for (int i = 0; i < 3; i++) begin
            expect_v(K_RDY, 16'd0, 0, "host_blocked");
            expect_v(K_RDA, 16'h22, 0, "ex_beats_host");
            if (i < 2) step();
        end
        expect_v(K_RET, 16'd7, 1, "retire_7");
        expect_v(K_WBD, 16'h22, 1, "wbd_ex22");

        step();
        ex_valid = 1'b0;
        expect_v(K_RDY, 16'd1, 0, "host_ready");
        expect_v(K_RDB, 16'h55, 0, "host_bypass");

        step();
        host_wr_valid = 1'b0;
        rd_adr_c = 3'd4;
        expect_v(K_RDA, 16'h55, 0, "host_commit_a");
        expect_v(K_RDB, 16'h55, 0, "host_commit_b");
        expect_v(K_RDC, 16'h55, 0, "host_commit_c");
        expect_v(K_RET, 16'd7, 0, "retire_host_unch");
        expect_v(K_WBV, 16'd1, 0, "wbv_host");
        expect_v(K_WBA, 16'd4, 0, "wba_host");
        expect_v(K_WBD, 16'h55, 0, "wbd_host");
        expect_v(K_WBV, 16'd0, 1, "wbv_idle");

        // Back-to-back commits: retire 7 -> FFFF -> wrap.
        step();
        ex_valid = 1'b1; ex_adr = 3'd0; ex_data = 9'h0AA; ex_load = 1'b0;
        for (int i = 0; i < 65528; i++) step();
        expect_v(K_RET, 16'hFFFF, 0, "retire_ffff");
        expect_v(K_LOAD, 16'd2, 0, "load_hold");
        expect_v(K_RET, 16'h0000, 1, "retire_wrap");
        step();
        step();

        // Mid-burst reset.
        rst_n = 1'b0;
        rd_adr_a = 3'd0; rd_adr_b = 3'd3; rd_adr_c = 3'd7;
        expect_v(K_RDA, 16'h00, 0, "rst_r0");
        expect_v(K_RDB, 16'h03, 0, "rst_r3");
        expect_v(K_RDC, 16'h07, 0, "rst_r7");
        expect_v(K_RET, 16'd0, 0, "rst_retire");
        expect_v(K_LOAD, 16'd0, 0, "rst_load");
        expect_v(K_OVF, 16'd0, 0, "rst_ovf");
        expect_v(K_RDY, 16'd0, 0, "rst_ready");
        expect_v(K_WBV, 16'd0, 0, "rst_wbv");
        expect_v(K_WBA, 16'd0, 0, "rst_wba");
        expect_v(K_WBD, 16'd0, 0, "rst_wbd");

        // First commit after release.
        step();
        rst_n = 1'b1;
        ex_adr = 3'd5; ex_data = 9'h133; ex_load = 1'b1;
        rd_adr_a = 3'd5;
        expect_v(K_RDA, 16'h33, 0, "post_rst_bypass");
        expect_v(K_RET, 16'd1, 1, "post_rst_retire");
        expect_v(K_LOAD, 16'd1, 1, "post_rst_load");
        expect_v(K_OVF, 16'd0, 1, "post_rst_ovf");
        expect_v(K_WBV, 16'd1, 1, "post_rst_wbv");

        step();
        ex_valid = 1'b0;
        step();
        step();
        if (sb_q.size() != 0) begin
            n_vec++;
            n_err++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
